// File: rtl/config_frame_writer_if.sv
// Config word stream between the bitstream loader and the frame writer.
interface config_frame_writer_if;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/config_frame_writer.sv
// Assembles one configuration frame from a header and NumRows data words,
// then pulses a single column/frame strobe with setup and hold around it.
module config_frame_writer #(
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20,
   parameter int NumRows         = 4,
   parameter int NumColumns      = 4,
   parameter int STROBE_WIDTH    = 2
) (
   input  logic                                  CLK,
   input  logic                                  reset,
   config_frame_writer_if.slave                  s,
   output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
   output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
   output logic                                  busy,
   output logic                                  err,
   output logic [15:0]                           frames_written
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] DRAIN  = 3'd2;
   localparam logic [2:0] SETUP  = 3'd3;
   localparam logic [2:0] STROBE = 3'd4;
   localparam logic [2:0] HOLD   = 3'd5;

   localparam int NS = NumColumns * MaxFramesPerCol;
   localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
   localparam int CW = (STROBE_WIDTH > 1) ? $clog2(STROBE_WIDTH) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(NumRows - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(STROBE_WIDTH - 1);
   localparam logic [7:0]    NCOL     = 8'(NumColumns);
   localparam logic [7:0]    NFRM     = 8'(MaxFramesPerCol);

   logic [2:0]                              state_q, state_d;
   logic [RW-1:0]                           row_q, row_d;
   logic [CW-1:0]                           stb_cnt_q, stb_cnt_d;
   logic [7:0]                              col_q, col_d, frame_q, frame_d;
   logic [NumRows-1:0][FrameBitsPerRow-1:0] data_q, data_d;
   logic [NS-1:0]                           strobe_q, strobe_d;
   logic [15:0]                             frames_written_q, frames_written_d;
   logic                                    err_q, err_d;
   logic [15:0]                             sel;
   logic                                    acc, sync_ok, in_range;

   assign s.in_ready     = (state_q == IDLE) || (state_q == LOAD) || (state_q == DRAIN);
   assign acc            = s.in_valid && s.in_ready;
   assign sync_ok        = (s.in_data[31:16] == 16'hFAB0);
   assign in_range       = (s.in_data[15:8] < NCOL) && (s.in_data[7:0] < NFRM);
   assign sel            = {8'd0, col_q} * 16'(MaxFramesPerCol) + {8'd0, frame_q};

   assign FrameData      = data_q;
   assign FrameStrobe    = strobe_q;
   assign busy           = (state_q != IDLE);
   assign err            = err_q;
   assign frames_written = frames_written_q;

   always_comb begin
      state_d          = state_q;
      row_d            = row_q;
      stb_cnt_d        = stb_cnt_q;
      col_d            = col_q;
      frame_d          = frame_q;
      data_d           = data_q;
      strobe_d         = strobe_q;
      frames_written_d = frames_written_q;
      err_d            = err_q;
      case (state_q)
         IDLE: if (acc) begin
            row_d = '0;
            if (!sync_ok) begin
               err_d = 1'b1;
            end else if (in_range) begin
               col_d   = s.in_data[15:8];
               frame_d = s.in_data[7:0];
               state_d = LOAD;
            end else begin
               // Bad index: still swallow the frame's rows so the stream stays aligned.
               err_d   = 1'b1;
               state_d = DRAIN;
            end
         end
         LOAD: if (acc) begin
            data_d[row_q] = s.in_data;
            row_d         = row_q + RW'(1);
            if (row_q == LAST_ROW) begin
               row_d   = '0;
               state_d = SETUP;
            end
         end
         DRAIN: if (acc) begin
            row_d = row_q + RW'(1);
            if (row_q == LAST_ROW) begin
               row_d   = '0;
               state_d = IDLE;
            end
         end
         SETUP: begin
            stb_cnt_d = '0;
            strobe_d  = {{(NS-1){1'b0}}, 1'b1} << sel;
            state_d   = STROBE;
         end
         STROBE: begin
            if (stb_cnt_q == STB_LAST) begin
               strobe_d         = '0;
               frames_written_d = frames_written_q + 16'd1;
               state_d          = HOLD;
            end else begin
               stb_cnt_d = stb_cnt_q + CW'(1);
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q          <= IDLE;
         row_q            <= '0;
         stb_cnt_q        <= '0;
         col_q            <= '0;
         frame_q          <= '0;
         data_q           <= '0;
         strobe_q         <= '0;
         frames_written_q <= '0;
         err_q            <= 1'b0;
      end else begin
         state_q          <= state_d;
         row_q            <= row_d;
         stb_cnt_q        <= stb_cnt_d;
         col_q            <= col_d;
         frame_q          <= frame_d;
         data_q           <= data_d;
         strobe_q         <= strobe_d;
         frames_written_q <= frames_written_d;
         err_q            <= err_d;
      end
   end
endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer: frame assembly, strobe timing, error paths, reset, wrap.
module tb_config_frame_writer;
   logic          CLK = 1'b0;
   logic          reset;
   logic [127:0]  FrameData;
   logic [79:0]   FrameStrobe;
   logic          busy, err;
   logic [15:0]   frames_written;
   int            n_cmp = 0;
   int            n_bad = 0;

   config_frame_writer_if bus ();

   config_frame_writer dut (
      .CLK(CLK), .reset(reset), .s(bus.slave),
      .FrameData(FrameData), .FrameStrobe(FrameStrobe),
      .busy(busy), .err(err), .frames_written(frames_written)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [79:0] sb(input int i);
      logic [79:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Present a word and wait (bounded) until it is accepted at a rising edge.
   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      bus.in_data  = w;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: in_ready observed 0 for %0d cycles, expected 1", n);
      end
      @(posedge CLK); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic frame(input string tag, input logic [31:0] hdr,
                        input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] r3,
                        input int idx, input logic [15:0] cnt_exp,
                        input bit hold_next, input logic [31:0] nxt);
      logic [127:0] fd;
      fd = {r3, r2, r1, r0};
      send(hdr);
      chk({tag, "_hdr_busy"}, 128'(busy), 128'(1'b1));
      send(r0); send(r1); send(r2);
      chk({tag, "_load_strobe"}, 128'(FrameStrobe), 128'(0));
      send(r3);
      if (hold_next) begin
         bus.in_valid = 1'b1;
         bus.in_data  = nxt;
      end
      chk({tag, "_setup_rdy"},    128'(bus.in_ready), 128'(1'b0));
      chk({tag, "_setup_strobe"}, 128'(FrameStrobe),  128'(0));
      chk({tag, "_setup_data"},   FrameData, fd);
      @(posedge CLK); #1;
      chk({tag, "_stb1"},      128'(FrameStrobe),  128'(sb(idx)));
      chk({tag, "_stb1_data"}, FrameData, fd);
      chk({tag, "_stb1_rdy"},  128'(bus.in_ready), 128'(1'b0));
      @(posedge CLK); #1;
      chk({tag, "_stb2"},      128'(FrameStrobe),  128'(sb(idx)));
      chk({tag, "_stb2_data"}, FrameData, fd);
      @(posedge CLK); #1;
      chk({tag, "_hold_strobe"}, 128'(FrameStrobe),    128'(0));
      chk({tag, "_hold_data"},   FrameData, fd);
      chk({tag, "_hold_rdy"},    128'(bus.in_ready),   128'(1'b0));
      chk({tag, "_count"},       128'(frames_written), 128'(cnt_exp));
      @(posedge CLK); #1;
      chk({tag, "_idle_busy"}, 128'(busy),         128'(1'b0));
      chk({tag, "_idle_rdy"},  128'(bus.in_ready), 128'(1'b1));
      chk({tag, "_idle_data"}, FrameData, fd);
   endtask

   initial begin
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_data",   FrameData,              128'(0));
      chk("rst_strobe", 128'(FrameStrobe),      128'(0));
      chk("rst_busy",   128'(busy),             128'(0));
      chk("rst_err",    128'(err),              128'(0));
      chk("rst_count",  128'(frames_written),   128'(0));
      chk("rst_rdy",    128'(bus.in_ready),     128'(1));
      reset = 1'b0;

      // col 1, frame 3 -> bit 23
      frame("t1", 32'hFAB0_0103, 32'hA0A0_A0A0, 32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'hA3A3_A3A3,
            23, 16'd1, 1'b0, 32'h0);
      chk("t1_err", 128'(err), 128'(0));

      send(32'h1234_0000);
      chk("t2_bad_err",  128'(err),  128'(1));
      chk("t2_bad_busy", 128'(busy), 128'(0));
      frame("t2", 32'hFAB0_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
            0, 16'd2, 1'b0, 32'h0);

      // col 4 / frame 20 are both out of range: rows drained, nothing written
      send(32'hFAB0_0414);
      chk("t3_err",  128'(err),  128'(1));
      chk("t3_busy", 128'(busy), 128'(1));
      send(32'hDEAD_0001); send(32'hDEAD_0002); send(32'hDEAD_0003);
      chk("t3_drain_strobe", 128'(FrameStrobe), 128'(0));
      send(32'hDEAD_0004);
      chk("t3_end_busy",   128'(busy),           128'(0));
      chk("t3_end_data",   FrameData, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
      chk("t3_end_strobe", 128'(FrameStrobe),    128'(0));
      chk("t3_end_count",  128'(frames_written), 128'(2));

      // back-to-back: col 2 frame 19 -> 59, col 3 frame 5 -> 65
      frame("t4a", 32'hFAB0_0213, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10,
            59, 16'd3, 1'b1, 32'hFAB0_0305);
      frame("t4b", 32'hFAB0_0305, 32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003,
            65, 16'd4, 1'b0, 32'h0);
      chk("t4_err_sticky", 128'(err), 128'(1));

      // reset during the first strobe cycle; col 2 frame 1 -> 41
      send(32'hFAB0_0201);
      send(32'h5555_0000); send(32'h5555_0001); send(32'h5555_0002); send(32'h5555_0003);
      @(posedge CLK); #1;
      chk("t5_stb", 128'(FrameStrobe), 128'(sb(41)));
      reset = 1'b1;
      @(posedge CLK); #1;
      chk("t5_strobe", 128'(FrameStrobe),    128'(0));
      chk("t5_data",   FrameData,            128'(0));
      chk("t5_busy",   128'(busy),           128'(0));
      chk("t5_count",  128'(frames_written), 128'(0));
      chk("t5_err",    128'(err),            128'(0));
      reset = 1'b0;

      @(negedge CLK);
      force dut.frames_written_q = 16'hFFFF;
      @(negedge CLK);
      release dut.frames_written_q;
      @(posedge CLK); #1;
      chk("t6_preload", 128'(frames_written), 128'(16'hFFFF));
      // col 3 frame 19 -> 79 (top bit)
      frame("t6", 32'hFAB0_0313, 32'h7777_0000, 32'h7777_1111, 32'h7777_2222, 32'h7777_3333,
            79, 16'h0000, 1'b0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
